// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder and a carry flop process the
// operands LSB first over WIDTH cycles, then present sum, carry and overflow.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             sum_bit;
    logic             cout_bit;

    always_comb begin
        sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        cout_bit = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction folds into addition: x + ~y + 1.
                    a_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = sub ? 1'b1 : ci;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout_bit;
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    s_d     = {sum_bit, acc_q[WIDTH-1:1]};
                    co_d    = cout_bit;
                    ovf_d   = carry_q ^ cout_bit;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=4: stimulus pushes expected
// results with their due cycle, a negedge monitor pops and checks on done.
module tb_serial_adder;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         busy;
    logic         done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_len = 0;
    exp_t sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .x    (x),
        .y    (y),
        .ci   (ci),
        .sub  (sub),
        .s    (s),
        .co   (co),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference: plain 5-bit arithmetic on the widened operands.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                   input logic cia, input logic suba);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb    = suba ? ~ya : ya;
        full  = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, (suba ? 1'b1 : cia)};
        e.s   = full[W-1:0];
        e.co  = full[W];
        e.ovf = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
        e.due = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("s", int'(s), int'(e.s));
                    check("co", int'(co), int'(e.co));
                    check("ovf", int'(ovf), int'(e.ovf));
                    check("done_cycle", cyc, e.due);
                    check("busy_len", busy_len, W);
                end
                busy_len = 0;
            end
        end
    end

    // Called just after a rising edge; capture happens on the next edge.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic cia,
                         input logic suba, input logic [W-1:0] es, input logic eco,
                         input logic eovf);
        exp_t e;
        x = xa; y = ya; ci = cia; sub = suba; start = 1'b1;
        e.s = es; e.co = eco; e.ovf = eovf; e.due = cyc + 5;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic cia,
                          input logic suba, input logic [W-1:0] es, input logic eco,
                          input logic eovf);
        @(posedge clk); #1;
        issue(xa, ya, cia, suba, es, eco, eovf);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t m;
        #2;
        check("rst_s", int'(s), 0);
        check("rst_co", int'(co), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        run_op(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
        run_op(4'h7, 4'h0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1);
        run_op(4'h3, 4'h5, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
        run_op(4'h5, 4'h3, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0);

        // start re-asserted mid-RUN with other operands must be ignored
        @(posedge clk); #1;
        issue(4'h2, 4'h3, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        x = 4'h9; y = 4'h9; sub = 1'b1; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("queue_after_ignore", sb.size(), 0);

        // leave s=8/ovf=1 in place so the reset clear is observable
        run_op(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
        @(posedge clk); #1;
        issue(4'h6, 4'h6, 1'b0, 1'b0, 4'hC, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_s", int'(s), 0);
        check("abort_co", int'(co), 0);
        check("abort_ovf", int'(ovf), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'h5, 4'h4, 1'b1, 1'b0, 4'hA, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // exhaustive sweep with start held high: each op begins in the DONE cycle
        @(posedge clk); #1;
        for (int op = 0; op < 768; op++) begin
            logic [W-1:0] xa, ya;
            logic         cia, suba;
            suba = (op >= 512);
            xa   = W'(op[3:0]);
            ya   = W'(op[7:4]);
            cia  = suba ? op[8] ^ op[0] : op[8];
            m = model(xa, ya, cia, suba);
            issue(xa, ya, cia, suba, m.s, m.co, m.ovf);
            repeat (5) @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("queue_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
